// File: rtl/seg_disp_ctrl.sv
// Multiplexed seven-segment display scanner with a four-register write/readback port.
// Blink support is compiled in only when SEG_BLINK_EN is defined.
module seg_disp_ctrl #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);

    if (DIGITS != 4 && DIGITS != 8) begin : g_bad_digits
        $error("seg_disp_ctrl: DIGITS must be 4 or 8");
    end
    if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
        $error("seg_disp_ctrl: SCAN_DIV must be in 2..65535");
    end
    if (BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_bad_blink_div
        $error("seg_disp_ctrl: BLINK_DIV must be in 1..255");
    end

    localparam logic [15:0]       PRESC_TC = 16'(SCAN_DIV - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};
`ifdef SEG_BLINK_EN
    localparam logic [3:0]        CTRL_MASK = 4'hF;
`else
    localparam logic [3:0]        CTRL_MASK = 4'hB;
`endif

    logic [31:0] data_q;
    logic [7:0]  dp_q;
    logic [7:0]  blank_q;
    logic [3:0]  ctrl_q;

    logic [15:0] presc_q;
    logic [2:0]  idx_q;
    logic        tc;
    logic        wrap;
    logic        blink_off;

    logic [31:0] data_view;
    logic [7:0]  lz_supp;
    logic        zero_run;
    logic [3:0]  cur_nib;
    logic        cur_dp;
    logic        cur_blank;
    logic [7:0]  an_on;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h00;
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            ctrl_q  <= '0;
        end else if (wr_en) begin
            case (wr_sel)
                2'b00: data_q  <= wr_data;
                2'b01: dp_q    <= wr_data[7:0];
                2'b10: blank_q <= wr_data[7:0];
                2'b11: ctrl_q  <= wr_data[3:0] & CTRL_MASK;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (wr_sel)
            2'b00: rd_data      = data_q;
            2'b01: rd_data[7:0] = dp_q;
            2'b10: rd_data[7:0] = blank_q;
            2'b11: rd_data[3:0] = ctrl_q;
        endcase
    end

    assign tc   = (presc_q == PRESC_TC);
    assign wrap = tc && (idx_q == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (!ctrl_q[0]) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (tc) begin
            presc_q <= '0;
            idx_q   <= wrap ? 3'd0 : idx_q + 3'd1;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

`ifdef SEG_BLINK_EN
    localparam logic [7:0] BLINK_TC = 8'(BLINK_DIV - 1);
    logic [7:0] blink_cnt_q;
    logic       blink_phase_q;

    // Counts completed scan rounds; restarts lit whenever the display is re-enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (!ctrl_q[0]) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt_q == BLINK_TC) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
            end
        end
    end

    assign blink_off = ctrl_q[2] & blink_phase_q;
`else
    assign blink_off = 1'b0;
`endif

    // A 4-digit build shows either the low or the high half of DATA.
    assign data_view = (DIGITS == 4 && ctrl_q[3]) ? {16'h0, data_q[31:16]} : data_q;

    always_comb begin
        lz_supp  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (data_view[4*k +: 4] == 4'h0);
            lz_supp[k] = zero_run;
        end
    end

    assign cur_nib   = data_view[{idx_q, 2'b00} +: 4];
    assign cur_dp    = dp_q[idx_q];
    assign cur_blank = blank_q[idx_q] | (ctrl_q[1] & lz_supp[idx_q]) | blink_off;
    assign an_on     = 8'h01 << idx_q;

    // The terminal-count cycle darkens the outputs, so the first cycle of every new index is dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else if (!ctrl_q[0] || tc) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= SEG_OFF ^ (cur_blank ? 8'h00 : {cur_dp, hex7(cur_nib)});
            an  <= AN_OFF ^ an_on[DIGITS-1:0];
        end
    end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl: an 8-digit and a 4-digit instance sharing one write bus.
module tb_seg_disp_ctrl;

    localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [3:0]  ctrl;
        logic [7:0]  exp_d0;
    } vec_t;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
    } sb_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        wr_en   = 1'b0;
    logic [1:0]  wr_sel  = 2'b00;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] rd8, rd4;
    logic [7:0]  seg8, seg4, an8;
    logic [3:0]  an4;

    int   n_vec = 0;
    int   n_err = 0;
    sb_t  sb_q[$];
    logic [7:0] prev_an8 = 8'hFF;

    always #5 clk = ~clk;

    seg_disp_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)) dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_data(rd8), .seg(seg8), .an(an8)
    );

    seg_disp_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_data(rd4), .seg(seg4), .an(an4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic chk_rd(input logic [1:0] sel, input logic [31:0] exp, input string name);
        wr_sel = sel;
        #1;
        chk(name, rd8, exp);
    endtask

    task automatic chk_digit4(input int k, input logic [7:0] exp, input string name);
        logic [3:0] want_an;
        bit found;
        want_an = ~(4'b0001 << k);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (an4 == want_an) found = 1'b1;
        end
        if (!found) begin
            n_vec++; n_err++;
            $display("FAIL %s: digit %0d never enabled, expected an=%h", name, k, want_an);
        end else begin
            chk(name, seg4, exp);
        end
    endtask

    function automatic logic [7:0] model_seg(input logic [31:0] d, input logic [7:0] dp,
                                             input logic [7:0] bl, input logic [3:0] c, input int k);
        logic off;
        logic z;
        off = bl[k];
        if (c[1] && k != 0) begin
            z = 1'b1;
            for (int j = k; j < 8; j++)
                if (d[4*j +: 4] != 4'h0) z = 1'b0;
            off = off | z;
        end
        return off ? 8'hFF : ~{dp[k], HEX7[d[4*k +: 4]]};
    endfunction

    // Scoreboard: each new slot on the 8-digit instance consumes one expected {an, seg}.
    always @(negedge clk) begin
        sb_t e;
        if (an8 != 8'hFF && prev_an8 == 8'hFF && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (an8 !== e.an || seg8 !== e.seg) begin
                n_err++;
                $display("FAIL sb_slot: got an=%h seg=%h, expected an=%h seg=%h", an8, seg8, e.an, e.seg);
            end
        end
        prev_an8 = an8;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [8];
        logic [3:0] ctrl_mask;
        ctrl_mask = BLINK_BUILT ? 4'hF : 4'hB;
        vt[0] = '{32'h1234_5678, 8'h00, 8'h00, 4'h1, 8'h80};
        vt[1] = '{32'h0000_00A0, 8'h00, 8'h00, 4'h3, 8'hC0};
        vt[2] = '{32'h1234_5678, 8'h01, 8'h80, 4'h1, 8'h00};
        vt[3] = '{32'h0000_0000, 8'h00, 8'h00, 4'h3, 8'hC0};
        vt[4] = '{32'h89AB_CDEF, 8'hAA, 8'h00, 4'h1, 8'h8E};
        vt[5] = '{32'h00F0_0000, 8'h00, 8'h04, 4'h3, 8'hC0};
        vt[6] = '{32'h0000_0000, 8'hFF, 8'h00, 4'h3, 8'h40};
        vt[7] = '{32'h1234_5678, 8'h00, 8'h00, 4'h9, 8'h80};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg8", seg8, 8'hFF);
        chk("rst_an8", an8, 8'hFF);
        chk("rst_seg4", seg4, 8'hFF);
        chk("rst_an4", an4, 4'hF);
        for (int s = 0; s < 4; s++) chk_rd(2'(s), 32'h0, $sformatf("rst_rd_%0d", s));
        @(posedge clk); #1;
        rst = 1'b0;

        // Register widths
        wr(2'b01, 32'hFFFF_FF01);
        chk_rd(2'b01, 32'h0000_0001, "rd_dp_width");
        wr(2'b10, 32'hFFFF_FF80);
        chk_rd(2'b10, 32'h0000_0080, "rd_blank_width");
        wr(2'b11, 32'hFFFF_FFFE);
        chk_rd(2'b11, {28'h0, 4'hE & ctrl_mask}, "rd_ctrl_width");
        wr(2'b11, 32'h0);
        wr(2'b01, 32'h0);
        wr(2'b10, 32'h0);

        // Digit walk with one dark cycle per slot
        wr(2'b00, 32'h1234_5678);
        wr(2'b11, 32'h1);
        @(posedge clk); #1;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ea;
            ea = (n % 4 == 3) ? 8'hFF : ~(8'h01 << ((n / 4) % 8));
            chk($sformatf("walk_an_%0d", n), an8, ea);
            if (n == 0)  chk("walk_d0_seg", seg8, 8'h80);
            if (n == 28) chk("walk_d7_seg", seg8, 8'hF9);
            @(posedge clk); #1;
        end

        // Table-driven digit content through the scoreboard
        foreach (vt[i]) begin
            int t;
            wr(2'b11, 32'h0);
            wr(2'b00, vt[i].data);
            wr(2'b01, {24'h0, vt[i].dp});
            wr(2'b10, {24'h0, vt[i].blank});
            for (int k = 0; k < 8; k++) begin
                sb_t e;
                e.an  = ~(8'h01 << k);
                e.seg = (k == 0) ? vt[i].exp_d0
                                 : model_seg(vt[i].data, vt[i].dp, vt[i].blank, vt[i].ctrl, k);
                sb_q.push_back(e);
            end
            wr(2'b11, {28'h0, vt[i].ctrl});
            t = 0;
            while (sb_q.size() != 0 && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            if (sb_q.size() != 0) begin
                n_vec++; n_err++;
                $display("FAIL vec_%0d_timeout: %0d slots outstanding, expected 0", i, sb_q.size());
                sb_q.delete();
            end
            chk_rd(2'b00, vt[i].data, $sformatf("vec_%0d_rd_data", i));
            chk_rd(2'b11, {28'h0, vt[i].ctrl & ctrl_mask}, $sformatf("vec_%0d_rd_ctrl", i));
        end

        // Blink: two lit rounds then two dark rounds when built in, always lit otherwise
        wr(2'b11, 32'h0);
        wr(2'b00, 32'h8888_8888);
        wr(2'b01, 32'h0);
        wr(2'b10, 32'h0);
        wr(2'b11, 32'h5);
        @(posedge clk); #1;
        for (int r = 0; r < 6; r++) begin
            bit lit;
            bit exp_lit;
            lit = 1'b0;
            exp_lit = BLINK_BUILT ? ((r % 4) < 2) : 1'b1;
            for (int c = 0; c < 32; c++) begin
                if (c % 4 == 1 && seg8 != 8'hFF) lit = 1'b1;
                @(posedge clk); #1;
            end
            chk($sformatf("blink_round_%0d", r), {31'h0, lit}, {31'h0, exp_lit});
        end
        chk_rd(2'b11, BLINK_BUILT ? 32'h5 : 32'h1, "blink_rd_ctrl");

        // Four-digit instance with half select
        wr(2'b11, 32'h0);
        wr(2'b00, 32'hABCD_1234);
        wr(2'b11, 32'h1);
        chk_digit4(0, 8'h99, "d4_lo_digit0");
        chk_digit4(3, 8'hF9, "d4_lo_digit3");
        wr(2'b11, 32'h9);
        repeat (6) @(posedge clk);
        #1;
        chk_digit4(0, 8'hA1, "d4_hi_digit0");
        chk_digit4(1, 8'hC6, "d4_hi_digit1");
        chk_digit4(3, 8'h88, "d4_hi_digit3");

        // Asynchronous reset in the middle of a slot
        wr(2'b11, 32'h0);
        wr(2'b00, 32'h1234_5678);
        wr(2'b01, 32'hFF);
        wr(2'b10, 32'h0);
        wr(2'b11, 32'h3);
        repeat (10) @(posedge clk);
        #3;
        chk("pre_rst_an8", an8, 8'hFB);
        chk("pre_rst_seg8", seg8, 8'h02);
        rst = 1'b1;
        #1;
        chk("mid_rst_seg8", seg8, 8'hFF);
        chk("mid_rst_an8", an8, 8'hFF);
        chk("mid_rst_seg4", seg4, 8'hFF);
        chk("mid_rst_an4", an4, 4'hF);
        for (int s = 0; s < 4; s++) begin
            chk_rd(2'(s), 32'h0, $sformatf("mid_rst_rd8_%0d", s));
            chk($sformatf("mid_rst_rd4_%0d", s), rd4, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_an8_dark", an8, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_disp_ctrl.md
SEG_DISP_CTRL -- requirements
Module: seg_disp_ctrl

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits; legal values 4 or 8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 2..65535.
REQ-003 Parameter BLINK_DIV, default 64: full scan rounds per blink half-period; legal range 1..255.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means seg and an are driven active-low, 0 means active-high.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 wr_en  input  1  register write strobe, sampled on rising clk.
REQ-008 wr_sel  input  2  register select: 00 DATA, 01 DP, 10 BLANK, 11 CTRL.
REQ-009 wr_data  input  32  write data.
REQ-010 rd_data  output  32  combinational readback of the register chosen by wr_sel.
REQ-011 seg  output  8  segments {dp,g,f,e,d,c,b,a}, registered.
REQ-012 an  output  DIGITS  digit enables, bit 0 = rightmost digit, registered.

Function
REQ-013 DATA[31:0] SHALL hold eight 4-bit hex nibbles, nibble k displayed on digit k.
REQ-014 DP[7:0] and BLANK[7:0] SHALL be per-digit decimal-point-on and force-blank masks; upper 24 bits read 0.
REQ-015 CTRL bits SHALL be [0] enable, [1] leading-zero suppress, [2] blink, [3] half select; other bits read 0.
REQ-016 A write SHALL update the selected register on the clk edge where wr_en=1; there is no other write path.
REQ-017 When DIGITS=4, digit k SHALL show nibble k+4*CTRL[3]; when DIGITS=8, CTRL[3] SHALL be ignored.
REQ-018 The prescaler SHALL count 0..SCAN_DIV-1 while enable=1; at terminal count the digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-019 When enable=0, the prescaler and index SHALL be held at 0 and all digits SHALL be off.
REQ-020 The cycle after an index change, all an bits SHALL be off for exactly one clk (anti-ghost); the new digit SHALL be driven from the following cycle.
REQ-021 Hex decode SHALL be 0-9, A, b, C, d, E, F in standard seven-segment form; dp SHALL equal DP[k].
REQ-022 With leading-zero suppress on, digit k SHALL be blanked if it and every higher displayed nibble are 0; digit 0 SHALL never be suppressed.
REQ-023 A blanked digit SHALL have all segments off, including dp, while its an bit is still cycled.
REQ-024 A register write coinciding with an index change SHALL be visible no later than the next digit slot.

Reset
REQ-025 On rst: DATA, DP, BLANK, CTRL, prescaler, index and blink counter SHALL be 0; seg and an SHALL be at the inactive level (all 1 when ACTIVE_LOW=1).
REQ-026 rst asserted mid-scan SHALL force the reset values immediately, independent of clk.

Configuration
REQ-027 With SEG_BLINK_EN defined, a blink counter SHALL toggle phase every BLINK_DIV index wraps; while CTRL[2]=1 and phase=1, all digits SHALL be blanked.
REQ-028 Without SEG_BLINK_EN, CTRL[2] SHALL read 0 and have no effect, and no blink counter SHALL be built.

Verification
REQ-029 Reset, then write CTRL=1 and DATA=0x12345678 with SCAN_DIV=4 -> an walks 0xFE, 0xFD, 0xFB, ... with one 0xFF gap per slot; digit 0 seg=0x80 (8), digit 7 seg=0xF9 (1).
REQ-030 DATA=0x0000_00A0, CTRL=0x3 -> digits 7..2 blanked (seg=0xFF); digit 1 seg=0x88 (A); digit 0 seg=0xC0 (0).
REQ-031 DP=0x01, BLANK=0x80 -> digit 0 has seg[7]=0; digit 7 seg=0xFF while an bit 7 still asserted in its slot.
REQ-032 DIGITS=4, DATA=0xABCD1234: CTRL=0x1 -> digit 0 seg=0x99 (4); CTRL=0x9 -> digit 0 seg=0xA1 (d).
REQ-033 Assert rst in the middle of a digit slot -> seg=0xFF and an all 1 within the same cycle; all registers read 0.
REQ-034 With SEG_BLINK_EN, BLINK_DIV=2, CTRL=0x5 -> display alternates between 2 lit rounds and 2 blank rounds.
